// File: rtl/rhs_stim_sequencer.sv
// rhs_stim_sequencer: biphasic stimulation sequencer for RHS-family headstages.
// Advances only on sample_tick. Configuration is shadowed when a run starts.
// Optional macro STIM_PULSE_COUNTER_EN adds a saturating 32-bit count of
// completed biphasic pulses. Without it, pulse_count is tied to 0.
//
// Command semantics: finite_start, infinite_start and infinite_stop are
// single-clk pulses with no handshake. A start is accepted only in IDLE and
// only when infinite_stop is low in the same cycle; infinite_start wins over
// finite_start. infinite_stop is remembered during an infinite run and acts at
// the end of the next PHASE2.
module rhs_stim_sequencer #(
  parameter int NUM_CHANNELS = 16,
  parameter int CNT_W        = 16,
  parameter int MAG_W        = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    sample_tick,
  input  logic [CNT_W-1:0]        pulse_length,
  input  logic [CNT_W-1:0]        inter_pulse_delay,
  input  logic [CNT_W-1:0]        inter_bipulse_delay,
  input  logic [CNT_W-1:0]        inter_train_delay,
  input  logic [CNT_W-1:0]        charge_recovery_time,
  input  logic [CNT_W-1:0]        bipulses_per_train_count,
  input  logic [CNT_W-1:0]        train_count,
  input  logic [MAG_W-1:0]        pulse_magnitude,
  input  logic                    rising_edge_first,
  input  logic                    bipolar_mode,
  input  logic [NUM_CHANNELS-1:0] mask_positive,
  input  logic [NUM_CHANNELS-1:0] mask_negative,
  input  logic                    finite_start,
  input  logic                    infinite_start,
  input  logic                    infinite_stop,
  output logic [NUM_CHANNELS-1:0] stim_on,
  output logic [NUM_CHANNELS-1:0] stim_pol,
  output logic [NUM_CHANNELS-1:0] charge_recovery,
  output logic [MAG_W-1:0]        stim_magnitude,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             pulse_count
);

  typedef enum logic [2:0] {
    IDLE, ARMED, PHASE1, INTERPHASE, PHASE2, INTER_BIPULSE, INTER_TRAIN, RECOVERY
  } state_t;

  localparam logic [CNT_W-1:0] ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W:0]   ONE_X = {{CNT_W{1'b0}}, 1'b1};

  state_t state, state_next;

  // Shadow configuration, captured on an accepted start.
  logic [CNT_W-1:0]        sh_plen, sh_ipd, sh_ibd, sh_itd, sh_rec, sh_bp, sh_tr;
  logic [MAG_W-1:0]        sh_mag;
  logic                    sh_ref, sh_bip, sh_inf;
  logic [NUM_CHANNELS-1:0] sh_pos, sh_neg;

  // Sequencing state.
  logic [CNT_W-1:0] cnt, bp_idx, tr_idx, dur_next, plen_eff;
  logic             stop_pending;

  logic                    start_ok, timer_done, p2_exit, more_bp, more_tr, stop_now;
  logic [NUM_CHANNELS-1:0] pos_ch, neg_ch, drv_ch;
  logic [NUM_CHANNELS-1:0] on_next, pol_next, rec_next;

  // A channel in both masks is positive only; negatives count only in bipolar mode.
  assign pos_ch = sh_pos;
  assign neg_ch = sh_bip ? (sh_neg & ~sh_pos) : '0;
  assign drv_ch = pos_ch | neg_ch;

  assign start_ok   = !infinite_stop &&
                      (infinite_start ||
                       (finite_start && bipulses_per_train_count != '0 && train_count != '0));
  assign timer_done = sample_tick && (cnt == '0);
  assign p2_exit    = (state == PHASE2) && timer_done;
  assign plen_eff   = (sh_plen == '0) ? ONE : sh_plen;
  assign more_bp    = (({1'b0, bp_idx} + ONE_X) < {1'b0, sh_bp});
  assign more_tr    = sh_inf || (({1'b0, tr_idx} + ONE_X) < {1'b0, sh_tr});
  assign stop_now   = sh_inf && (stop_pending || infinite_stop);

  // Next-state logic; zero-length delays are skipped within the same tick.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:          if (start_ok) state_next = ARMED;
      ARMED:         if (sample_tick) state_next = PHASE1;
      PHASE1:        if (timer_done) state_next = (sh_ipd != '0) ? INTERPHASE : PHASE2;
      INTERPHASE:    if (timer_done) state_next = PHASE2;
      PHASE2: begin
        if (timer_done) begin
          if (stop_now || (!more_bp && !more_tr))
            state_next = (sh_rec != '0) ? RECOVERY : IDLE;
          else if (more_bp)
            state_next = (sh_ibd != '0) ? INTER_BIPULSE : PHASE1;
          else
            state_next = (sh_itd != '0) ? INTER_TRAIN : PHASE1;
        end
      end
      INTER_BIPULSE: if (timer_done) state_next = PHASE1;
      INTER_TRAIN:   if (timer_done) state_next = PHASE1;
      RECOVERY:      if (timer_done) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // Duration of the state being entered.
  always_comb begin
    dur_next = ONE;
    case (state_next)
      PHASE1, PHASE2: dur_next = plen_eff;
      INTERPHASE:     dur_next = sh_ipd;
      INTER_BIPULSE:  dur_next = sh_ibd;
      INTER_TRAIN:    dur_next = sh_itd;
      RECOVERY:       dur_next = sh_rec;
      default:        dur_next = ONE;
    endcase
  end

  // Electrode drive for the state being entered.
  always_comb begin
    on_next  = '0;
    pol_next = '0;
    rec_next = '0;
    case (state_next)
      PHASE1: begin
        on_next  = drv_ch;
        pol_next = (pos_ch & {NUM_CHANNELS{sh_ref}}) | (neg_ch & {NUM_CHANNELS{~sh_ref}});
      end
      PHASE2: begin
        on_next  = drv_ch;
        pol_next = (pos_ch & {NUM_CHANNELS{~sh_ref}}) | (neg_ch & {NUM_CHANNELS{sh_ref}});
      end
      RECOVERY: rec_next = drv_ch;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Shadow configuration capture on an accepted start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_plen <= '0; sh_ipd <= '0; sh_ibd <= '0; sh_itd <= '0; sh_rec <= '0;
      sh_bp   <= '0; sh_tr  <= '0; sh_mag <= '0;
      sh_ref  <= 1'b0; sh_bip <= 1'b0; sh_inf <= 1'b0;
      sh_pos  <= '0; sh_neg <= '0;
    end else if (state == IDLE && start_ok) begin
      sh_plen <= pulse_length;
      sh_ipd  <= inter_pulse_delay;
      sh_ibd  <= inter_bipulse_delay;
      sh_itd  <= inter_train_delay;
      sh_rec  <= charge_recovery_time;
      sh_bp   <= bipulses_per_train_count;
      sh_tr   <= train_count;
      sh_mag  <= pulse_magnitude;
      sh_ref  <= rising_edge_first;
      sh_bip  <= bipolar_mode;
      sh_inf  <= infinite_start;
      sh_pos  <= mask_positive;
      sh_neg  <= mask_negative;
    end
  end

  // Duration timer, repetition indices and the latched stop request.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt          <= '0;
      bp_idx       <= '0;
      tr_idx       <= '0;
      stop_pending <= 1'b0;
    end else begin
      if (state == IDLE) begin
        stop_pending <= 1'b0;
        if (start_ok) begin
          bp_idx <= '0;
          tr_idx <= '0;
        end
      end else if (sh_inf && infinite_stop) begin
        stop_pending <= 1'b1;
      end
      if (state_next != state)
        cnt <= dur_next - ONE;
      else if (sample_tick && cnt != '0)
        cnt <= cnt - ONE;
      if (p2_exit) begin
        if (more_bp) begin
          bp_idx <= bp_idx + ONE;
        end else begin
          bp_idx <= '0;
          if (!sh_inf) tr_idx <= tr_idx + ONE;
        end
      end
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stim_on         <= '0;
      stim_pol        <= '0;
      charge_recovery <= '0;
      stim_magnitude  <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      stim_on         <= on_next;
      stim_pol        <= pol_next;
      charge_recovery <= rec_next;
      stim_magnitude  <= (|on_next) ? sh_mag : '0;
      busy            <= (state_next != IDLE);
      done            <= (state != IDLE) && (state_next == IDLE);
    end
  end

`ifdef STIM_PULSE_COUNTER_EN
  logic [31:0] pulse_cnt_q;

  // Saturating count of completed biphasic pulses, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                              pulse_cnt_q <= '0;
    else if (p2_exit && pulse_cnt_q != '1)  pulse_cnt_q <= pulse_cnt_q + 32'd1;
  end

  assign pulse_count = pulse_cnt_q;
`else
  assign pulse_count = '0;
`endif

endmodule

// File: tb/tb_rhs_stim_sequencer.sv
// tb_rhs_stim_sequencer: randomized bench for rhs_stim_sequencer. The model
// expands each run's configuration into a per-tick list of expected outputs.
module tb_rhs_stim_sequencer;

  localparam int N  = 16;
  localparam int CW = 16;
  localparam int MW = 8;
  localparam int VW = 2 + MW + 3 * N;

  localparam int K_P1 = 0, K_IP = 1, K_P2 = 2, K_GAP = 3, K_REC = 4, K_IDLE = 5;

  typedef struct {
    logic [CW-1:0] plen, ipd, ibd, itd, rec, bp, tr;
    logic [MW-1:0] mag;
    logic          ref_first, bip;
    logic [N-1:0]  pos, neg;
  } cfg_t;

  logic          clk, rstn, sample_tick;
  logic [CW-1:0] pulse_length, inter_pulse_delay, inter_bipulse_delay, inter_train_delay;
  logic [CW-1:0] charge_recovery_time, bipulses_per_train_count, train_count;
  logic [MW-1:0] pulse_magnitude;
  logic          rising_edge_first, bipolar_mode;
  logic [N-1:0]  mask_positive, mask_negative;
  logic          finite_start, infinite_start, infinite_stop;
  logic [N-1:0]  stim_on, stim_pol, charge_recovery;
  logic [MW-1:0] stim_magnitude;
  logic          busy, done;
  logic [31:0]   pulse_count;

  rhs_stim_sequencer #(.NUM_CHANNELS(N), .CNT_W(CW), .MAG_W(MW)) dut (
    .clk(clk), .rstn(rstn), .sample_tick(sample_tick),
    .pulse_length(pulse_length), .inter_pulse_delay(inter_pulse_delay),
    .inter_bipulse_delay(inter_bipulse_delay), .inter_train_delay(inter_train_delay),
    .charge_recovery_time(charge_recovery_time),
    .bipulses_per_train_count(bipulses_per_train_count), .train_count(train_count),
    .pulse_magnitude(pulse_magnitude), .rising_edge_first(rising_edge_first),
    .bipolar_mode(bipolar_mode), .mask_positive(mask_positive), .mask_negative(mask_negative),
    .finite_start(finite_start), .infinite_start(infinite_start), .infinite_stop(infinite_stop),
    .stim_on(stim_on), .stim_pol(stim_pol), .charge_recovery(charge_recovery),
    .stim_magnitude(stim_magnitude), .busy(busy), .done(done), .pulse_count(pulse_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard
  logic [VW-1:0] exp_q[$];
  int stop_idx, abort_idx, plan_pulses, exp_pulses, last_done_tick;
  bit seen15;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [VW-1:0] observed();
    return {busy, done, stim_magnitude, charge_recovery, stim_pol, stim_on};
  endfunction

  // Expected outputs for one tick of a given kind of segment.
  function automatic logic [VW-1:0] vec(input cfg_t c, input int kind);
    logic [N-1:0]  pos, neg, drv, on, pol, rc;
    logic [MW-1:0] mag;
    logic          b, d;
    pos = c.pos;
    neg = c.bip ? (c.neg & ~c.pos) : '0;
    drv = pos | neg;
    on = '0; pol = '0; rc = '0; b = 1'b1; d = 1'b0;
    if (kind == K_P1) begin
      on  = drv;
      pol = c.ref_first ? pos : neg;
    end else if (kind == K_P2) begin
      on  = drv;
      pol = c.ref_first ? neg : pos;
    end else if (kind == K_REC) begin
      rc = drv;
    end else if (kind == K_IDLE) begin
      b = 1'b0;
      d = 1'b1;
    end
    mag = (on != '0) ? c.mag : '0;
    return {b, d, mag, rc, pol, on};
  endfunction

  function automatic void push_n(input cfg_t c, input int kind, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(vec(c, kind));
  endfunction

  // Expands a run into the list of per-tick expected outputs.
  function automatic void build(input cfg_t c, input int trains_n, input int stop_pid,
                                input int abort_pid);
    int pid = 0;
    bit stopped = 0;
    int ple = (c.plen == '0) ? 1 : int'(c.plen);
    int bp  = int'(c.bp);
    exp_q.delete();
    stop_idx  = -1;
    abort_idx = -1;
    for (int t = 0; t < trains_n && !stopped; t++) begin
      for (int b = 0; b < bp && !stopped; b++) begin
        if (pid == stop_pid) stop_idx = exp_q.size();
        push_n(c, K_P1, ple);
        push_n(c, K_IP, int'(c.ipd));
        if (pid == abort_pid) abort_idx = exp_q.size();
        push_n(c, K_P2, ple);
        if (pid == stop_pid)       stopped = 1;
        else if (b < bp - 1)       push_n(c, K_GAP, int'(c.ibd));
        else if (t < trains_n - 1) push_n(c, K_GAP, int'(c.itd));
        pid++;
      end
    end
    plan_pulses = pid;
    push_n(c, K_REC, int'(c.rec));
    push_n(c, K_IDLE, 1);
  endfunction

  // Driver tasks
  task automatic apply_cfg(input cfg_t c);
    pulse_length             = c.plen;
    inter_pulse_delay        = c.ipd;
    inter_bipulse_delay      = c.ibd;
    inter_train_delay        = c.itd;
    charge_recovery_time     = c.rec;
    bipulses_per_train_count = c.bp;
    train_count              = c.tr;
    pulse_magnitude          = c.mag;
    rising_edge_first        = c.ref_first;
    bipolar_mode             = c.bip;
    mask_positive            = c.pos;
    mask_negative            = c.neg;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.plen = CW'($urandom_range(0, 3));
    c.ipd  = CW'($urandom_range(0, 2));
    c.ibd  = CW'($urandom_range(0, 3));
    c.itd  = CW'($urandom_range(0, 3));
    c.rec  = CW'($urandom_range(0, 3));
    c.bp   = CW'($urandom_range(1, 3));
    c.tr   = CW'($urandom_range(1, 3));
    c.mag  = MW'($urandom);
    c.ref_first = 1'($urandom_range(0, 1));
    c.bip  = 1'($urandom_range(0, 1));
    c.pos  = N'($urandom);
    c.neg  = N'($urandom);
    return c;
  endfunction

  task automatic do_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    sample_tick = 1'b0; finite_start = 1'b0; infinite_start = 1'b0; infinite_stop = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    exp_pulses = 0;
    @(negedge clk);
  endtask

  task automatic check_pulse_count(input string tag);
`ifdef STIM_PULSE_COUNTER_EN
    check(tag, 64'(pulse_count), 64'(exp_pulses));
`else
    check(tag, 64'(pulse_count), 64'd0);
`endif
  endtask

  // One run: start, tick through the expected list, optionally stop or reset.
  task automatic run_seq(input cfg_t c, input bit inf, input bit both, input int stop_pid,
                         input int abort_pid, input bit scramble);
    int  idx = 0;
    int  gap;
    bit  aborted = 0;
    logic [VW-1:0] e;
    build(c, inf ? 4 : int'(c.tr), inf ? stop_pid : -1, abort_pid);
    last_done_tick = -1;
    apply_cfg(c);
    infinite_start = inf;
    finite_start   = both | !inf;
    @(negedge clk);
    infinite_start = 1'b0;
    finite_start   = 1'b0;
    check("armed", 64'(observed()), 64'({1'b1, {(VW-1){1'b0}}}));
    if (scramble) apply_cfg(rand_cfg());
    while (exp_q.size() > 0 && !aborted) begin
      do_tick();
      e = exp_q.pop_front();
      check("tick", 64'(observed()), 64'(e));
      if (stim_on[15]) seen15 = 1;
      if (done && last_done_tick < 0) last_done_tick = idx + 1;
      if (idx == abort_idx) begin
        rstn = 1'b0;
        #1;
        check("reset_outputs", 64'(observed()), 64'd0);
        check("reset_count", 64'(pulse_count), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        exp_pulses = 0;
        exp_q.delete();
        aborted = 1;
      end else if (exp_q.size() > 0) begin
        if (inf && idx == stop_idx) begin
          infinite_stop = 1'b1;
          @(negedge clk);
          infinite_stop = 1'b0;
        end
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          if (scramble) begin
            apply_cfg(rand_cfg());
            finite_start   = ($urandom_range(0, 3) == 0);
            infinite_start = ($urandom_range(0, 3) == 0);
            infinite_stop  = !inf && ($urandom_range(0, 3) == 0);
          end
          @(negedge clk);
          finite_start = 1'b0; infinite_start = 1'b0; infinite_stop = 1'b0;
        end
      end
      idx++;
    end
    if (!aborted) begin
      @(negedge clk);
      check("done_clears", 64'({busy, done}), 64'd0);
      exp_pulses += plan_pulses;
      check_pulse_count("pulse_count");
    end
  endtask

  cfg_t a, c;

  initial begin
    exp_pulses = 0;
    seen15 = 0;
    a.plen = 16'd1; a.ipd = 16'd0; a.ibd = 16'd3; a.itd = 16'd7; a.rec = 16'd8;
    a.bp = 16'd8; a.tr = 16'd4; a.mag = 8'h5A; a.ref_first = 1'b1; a.bip = 1'b1;
    a.pos = 16'h0080; a.neg = 16'h8000;
    apply_cfg(a);
    do_reset();
    check("reset_state", 64'(observed()), 64'd0);
    check("reset_count", 64'(pulse_count), 64'd0);

    // Reference finite run, then the same run with inputs churning while busy.
    run_seq(a, 0, 0, -1, -1, 0);
    check("done_latency", 64'(last_done_tick - 1), 64'd177);
    run_seq(a, 0, 0, -1, -1, 1);
    check("done_latency_scrambled", 64'(last_done_tick - 1), 64'd177);

    // Infinite run stopped in the middle of PHASE1 of pulse 13.
    run_seq(a, 1, 0, 13, -1, 0);

    // Unipolar: the negative-mask channel never fires.
    c = a; c.bip = 1'b0; c.tr = 16'd1;
    seen15 = 0;
    run_seq(c, 0, 0, -1, -1, 1);
    check("ch15_unipolar", 64'(seen15), 64'd0);

    // Reset in PHASE2 of pulse 2, then a normal finite run.
    run_seq(a, 0, 0, -1, 2, 0);
    c = a; c.tr = 16'd1; c.bp = 16'd2;
    run_seq(c, 0, 0, -1, -1, 0);

    // Finite start with train_count = 0 is ignored.
    c = a; c.tr = 16'd0;
    apply_cfg(c);
    finite_start = 1'b1;
    @(negedge clk);
    finite_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("zero_trains_idle", 64'({busy, done}), 64'd0);
      do_tick();
    end

    // Start cancelled by a simultaneous stop.
    apply_cfg(a);
    finite_start = 1'b1; infinite_stop = 1'b1;
    @(negedge clk);
    finite_start = 1'b0; infinite_stop = 1'b0;
    check("start_cancel", 64'({busy, done}), 64'd0);
    do_tick();
    check("start_cancel_tick", 64'(observed()), 64'd0);

    // Both starts together run in infinite mode.
    c = rand_cfg();
    run_seq(c, 1, 1, int'($urandom_range(0, 3)), -1, 1);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      bit inf;
      c = rand_cfg();
      inf = 1'($urandom_range(0, 1));
      run_seq(c, inf, 0, int'($urandom_range(0, 4 * int'(c.bp) - 1)), -1, 1'($urandom_range(0, 1)));
    end

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
